experiment_responder: RTL and testbench
=======================================

Name: experiment_responder

Overview:
Synthesizable plant emulator that answers the experiment-phase sequencer's outputs on the same 200 MHz clock (5 ns period). It accepts output_trigger and detonator_triggered from the sequencer and returns detector_ready and wire_sensor, with programmable detector dead-time and wire-break delay. It also flags protocol violations. It is used for board bring-up without a real detector or detonator, and as a bench responder.

Parameters:
DETECTOR_INIT_CYCLES, 1000, cycles detector_ready stays low after reset or after enable rises
DETECTOR_BUSY_CYCLES, 1_280_000, cycles detector_ready stays low after an accepted trigger (6.4 ms)
TRIGGER_MIN_LEN, 200, minimum legal output_trigger high time in cycles (1 us)
WIRE_DELAY_CYCLES, 2000, cycles from detonator edge detection to wire_sensor rise
WIRE_PULSE_CYCLES, 200, wire_sensor high time in cycles
CNT_WIDTH, 21, width of all internal timers; must hold the largest cycle parameter

Ports:
clock  in  1  system clock
reset_signal  in  1  asynchronous, active-high reset
enable  in  1  emulator active; low forces idle
output_trigger  in  1  detector trigger from the sequencer
detonator_triggered  in  1  detonator pulse from the sequencer
clear_errors  in  1  single-cycle pulse that clears error_flags
detector_ready  out  1  detector able to accept a trigger
wire_sensor  out  1  emulated wire-break sensor
trigger_count  out  16  accepted triggers, saturating
detonate_count  out  16  accepted detonations, saturating
error_flags  out  3  [0] trigger while not ready, [1] trigger shorter than TRIGGER_MIN_LEN, [2] detonation while wire sequence active

Behaviour:
- Clock and reset: one clock. reset_signal is asynchronous and active-high. In reset, all outputs are 0, the detector FSM is in D_INIT with its timer loaded to DETECTOR_INIT_CYCLES, and the wire FSM is in W_IDLE.
- Input sampling:
  - Inputs are registered once (trig_q, det_q).
  - A rising edge is "input sampled 1 at edge k and 0 at edge k-1"; it is detected at edge k.
  - All outputs are registered.
- Detector FSM:
  - D_INIT:
    - detector_ready=0; timer counts down.
    - After exactly DETECTOR_INIT_CYCLES cycles (counted while enable=1), go to D_READY.
  - D_READY:
    - detector_ready=1.
    - A trigger rise is accepted: go to D_BUSY, load timer, and increment trigger_count (saturating at 0xFFFF).
    - detector_ready falls one clock after the detecting edge.
  - D_BUSY:
    - detector_ready=0 for exactly DETECTOR_BUSY_CYCLES cycles, then return to D_READY.
    - A trigger rise here sets error_flags[0]. It is ignored: no timer restart and no count.
  - A trigger rise in D_INIT also sets error_flags[0].
- Trigger width check:
  - An independent counter counts consecutive cycles with output_trigger sampled high, saturating at TRIGGER_MIN_LEN.
  - On the falling edge, if the count is below TRIGGER_MIN_LEN, error_flags[1] is set.
  - Applies to every pulse, accepted or not.
- Wire FSM:
  - W_IDLE:
    - wire_sensor=0.
    - A detonator rise goes to W_DELAY and increments detonate_count (saturating).
  - W_DELAY: wait WIRE_DELAY_CYCLES, then go to W_PULSE.
    - wire_sensor rises exactly WIRE_DELAY_CYCLES+1 clocks after the detecting edge.
  - W_PULSE: wire_sensor=1 for exactly WIRE_PULSE_CYCLES cycles, then return to W_IDLE.
  - A detonator rise in W_DELAY or W_PULSE sets error_flags[2] and is ignored.
- Errors:
  - error_flags bits are sticky.
  - clear_errors clears all bits.
  - If a set event and clear_errors occur in the same cycle, set wins.
- enable:
  - enable=0 forces the detector FSM to D_INIT (timer reloaded) and the wire FSM to W_IDLE.
  - detector_ready and wire_sensor are 0 on the next clock.
  - Counters and error_flags hold.
  - Edges occurring while enable=0 are neither counted nor flagged.
  - When enable rises, full init timing restarts.
- Reset mid-operation: immediately returns everything to the reset values above; counters and flags are zeroed.
- Simultaneous events: both FSMs are independent; a trigger rise and a detonator rise in the same cycle are both processed.

Test Plan:
Bench parameters for all scenarios: INIT=10, BUSY=50, MIN=4, WIRE_DELAY=20, WIRE_PULSE=5.
1. Reset release with enable=1 -> detector_ready rises after exactly 10 enabled cycles; all counts are 0 and error_flags=000.
2. 6-cycle output_trigger pulse in D_READY -> detector_ready low one clock after detection for exactly 50 cycles; trigger_count=1; error_flags=000.
3. Second 6-cycle trigger 20 cycles into BUSY -> error_flags[0]=1; ready still returns at the original cycle 50; trigger_count stays 1. Then clear_errors -> error_flags=000.
4. 2-cycle trigger pulse while ready -> accepted (trigger_count+1), error_flags[1]=1. clear_errors in the same cycle as the falling-edge detection -> bit stays 1.
5. Detonator pulse -> wire_sensor high at detection+21 clocks for 5 cycles; detonate_count=1. Second detonator rise at +10 -> error_flags[2]=1, no second wire pulse.
6. enable dropped mid-BUSY, then asserted 3 cycles later -> detector_ready=0 and counts held; ready rises 10 cycles after enable returns. Async reset pulse mid-wire pulse -> wire_sensor=0 immediately and counts cleared.

Source files
------------

// File: rtl/experiment_responder.sv
// experiment_responder: detector/detonator plant emulator answering the experiment sequencer
module experiment_responder #(
  parameter int DETECTOR_INIT_CYCLES = 1000,
  parameter int DETECTOR_BUSY_CYCLES = 1_280_000,
  parameter int TRIGGER_MIN_LEN = 200,
  parameter int WIRE_DELAY_CYCLES = 2000,
  parameter int WIRE_PULSE_CYCLES = 200,
  parameter int CNT_WIDTH = 21
) (
  input  logic        clock,
  input  logic        reset_signal,
  input  logic        enable,
  input  logic        output_trigger,
  input  logic        detonator_triggered,
  input  logic        clear_errors,
  output logic        detector_ready,
  output logic        wire_sensor,
  output logic [15:0] trigger_count,
  output logic [15:0] detonate_count,
  output logic [2:0]  error_flags
);
  typedef enum logic [1:0] {D_INIT, D_READY, D_BUSY} d_state_t;
  typedef enum logic [1:0] {W_IDLE, W_DELAY, W_PULSE} w_state_t;
  localparam logic [CNT_WIDTH-1:0] ONE = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] INIT_LD = CNT_WIDTH'(DETECTOR_INIT_CYCLES);
  localparam logic [CNT_WIDTH-1:0] BUSY_LD = CNT_WIDTH'(DETECTOR_BUSY_CYCLES);
  localparam logic [CNT_WIDTH-1:0] MIN_LD = CNT_WIDTH'(TRIGGER_MIN_LEN);
  localparam logic [CNT_WIDTH-1:0] DELAY_LD = CNT_WIDTH'(WIRE_DELAY_CYCLES);
  localparam logic [CNT_WIDTH-1:0] PULSE_LD = CNT_WIDTH'(WIRE_PULSE_CYCLES);
  logic trig_q, trig_p, det_q, det_p;
  logic trig_rise, trig_fall, det_rise;
  logic trig_acc, trig_err, det_acc, det_err, short_err;
  d_state_t d_state, d_next;
  w_state_t w_state, w_next;
  logic [CNT_WIDTH-1:0] d_tmr, d_tmr_next, w_tmr, w_tmr_next, hi_len;
  assign trig_rise = trig_q & ~trig_p;
  assign trig_fall = ~trig_q & trig_p;
  assign det_rise = det_q & ~det_p;
  assign short_err = enable & trig_fall & (hi_len < MIN_LD);
  // timers hold the remaining cycle count; the state advances on the edge where it reads 1
  always_comb begin
    d_next = d_state;
    d_tmr_next = d_tmr;
    trig_acc = 1'b0;
    trig_err = 1'b0;
    if (!enable) begin
      d_next = D_INIT;
      d_tmr_next = INIT_LD;
    end else begin
      case (d_state)
        D_READY: begin
          trig_acc = trig_rise;
          d_next = trig_rise ? D_BUSY : D_READY;
          d_tmr_next = trig_rise ? BUSY_LD : d_tmr;
        end
        default: begin
          trig_err = trig_rise;
          d_next = (d_tmr <= ONE) ? D_READY : d_state;
          d_tmr_next = (d_tmr <= ONE) ? d_tmr : d_tmr - ONE;
        end
      endcase
    end
  end
  always_comb begin
    w_next = w_state;
    w_tmr_next = w_tmr;
    det_acc = 1'b0;
    det_err = 1'b0;
    if (!enable) begin
      w_next = W_IDLE;
    end else begin
      case (w_state)
        W_IDLE: begin
          det_acc = det_rise;
          w_next = det_rise ? W_DELAY : W_IDLE;
          w_tmr_next = det_rise ? DELAY_LD : w_tmr;
        end
        W_DELAY: begin
          det_err = det_rise;
          w_next = (w_tmr <= ONE) ? W_PULSE : W_DELAY;
          w_tmr_next = (w_tmr <= ONE) ? PULSE_LD : w_tmr - ONE;
        end
        default: begin
          det_err = det_rise;
          w_next = (w_tmr <= ONE) ? W_IDLE : W_PULSE;
          w_tmr_next = (w_tmr <= ONE) ? w_tmr : w_tmr - ONE;
        end
      endcase
    end
  end
  always_ff @(posedge clock or posedge reset_signal) begin
    if (reset_signal) begin
      trig_q <= 1'b0;
      trig_p <= 1'b0;
      det_q <= 1'b0;
      det_p <= 1'b0;
      d_state <= D_INIT;
      d_tmr <= INIT_LD;
      w_state <= W_IDLE;
      w_tmr <= '0;
      hi_len <= '0;
      detector_ready <= 1'b0;
      wire_sensor <= 1'b0;
      trigger_count <= '0;
      detonate_count <= '0;
      error_flags <= '0;
    end else begin
      trig_q <= output_trigger;
      trig_p <= trig_q;
      det_q <= detonator_triggered;
      det_p <= det_q;
      d_state <= d_next;
      d_tmr <= d_tmr_next;
      w_state <= w_next;
      w_tmr <= w_tmr_next;
      hi_len <= trig_q ? ((hi_len < MIN_LD) ? hi_len + ONE : hi_len) : '0;
      detector_ready <= d_next == D_READY;
      wire_sensor <= w_next == W_PULSE;
      if (trig_acc && trigger_count != 16'hFFFF) trigger_count <= trigger_count + 16'd1;
      if (det_acc && detonate_count != 16'hFFFF) detonate_count <= detonate_count + 16'd1;
      error_flags <= (clear_errors ? 3'b000 : error_flags) | {det_err, short_err, trig_err};
    end
  end
endmodule

// File: tb/tb_experiment_responder.sv
// tb_experiment_responder: directed table, async-reset sequence and random run against a timestamp model
module tb_experiment_responder;
  localparam int INIT = 10, BUSY = 50, MIN = 4, WD = 20, WP = 5;
  typedef struct {
    int cyc;
    logic en, tg, dt, cl;
    logic rdy, wr;
    logic [15:0] tc, dc;
    logic [2:0] er;
  } vec_t;
  logic clock = 1'b0;
  logic reset_signal = 1'b0;
  logic enable = 1'b1;
  logic output_trigger = 1'b0;
  logic detonator_triggered = 1'b0;
  logic clear_errors = 1'b0;
  logic detector_ready, wire_sensor;
  logic [15:0] trigger_count, detonate_count;
  logic [2:0] error_flags;
  int vectors = 0, miscompares = 0;
  int n, ready_at, w_on, w_off;
  bit prev_en, m_ready, m_wire;
  logic [15:0] m_tc, m_dc;
  logic [2:0] m_err;
  bit ht [0:8191];
  bit hd [0:8191];
  vec_t tbl [0:27];
  always #5 clock = ~clock;
  experiment_responder #(
    .DETECTOR_INIT_CYCLES(INIT),
    .DETECTOR_BUSY_CYCLES(BUSY),
    .TRIGGER_MIN_LEN(MIN),
    .WIRE_DELAY_CYCLES(WD),
    .WIRE_PULSE_CYCLES(WP),
    .CNT_WIDTH(21)
  ) dut (
    .clock(clock),
    .reset_signal(reset_signal),
    .enable(enable),
    .output_trigger(output_trigger),
    .detonator_triggered(detonator_triggered),
    .clear_errors(clear_errors),
    .detector_ready(detector_ready),
    .wire_sensor(wire_sensor),
    .trigger_count(trigger_count),
    .detonate_count(detonate_count),
    .error_flags(error_flags)
  );
  function automatic bit st(input int i);
    return (i < 1) ? 1'b0 : ht[i];
  endfunction
  function automatic bit sd(input int i);
    return (i < 1) ? 1'b0 : hd[i];
  endfunction
  function automatic logic [36:0] dut_out();
    return {detector_ready, wire_sensor, trigger_count, detonate_count, error_flags};
  endfunction
  task automatic check(input string name, input logic [36:0] got, input logic [36:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s at edge %0d: got %h expected %h", name, n, got, exp);
    end
  endtask
  task automatic model_reset();
    n = 0;
    ready_at = 32'h7fffffff;
    w_on = 0;
    w_off = 0;
    prev_en = 1'b0;
    m_ready = 1'b0;
    m_wire = 1'b0;
    m_tc = '0;
    m_dc = '0;
    m_err = '0;
  endtask
  // model works in absolute edge numbers: when ready returns, when the wire pulse starts/ends
  task automatic model_step();
    bit tr, tf, dr;
    bit [2:0] set;
    int run;
    n++;
    ht[n] = output_trigger;
    hd[n] = detonator_triggered;
    tr = st(n-1) && !st(n-2);
    tf = !st(n-1) && st(n-2);
    dr = sd(n-1) && !sd(n-2);
    set = '0;
    if (enable) begin
      if (!prev_en) ready_at = n + INIT - 1;
      if (tr) begin
        if (m_ready) begin
          ready_at = n + BUSY;
          if (m_tc != 16'hFFFF) m_tc++;
        end else set[0] = 1'b1;
      end
      if (tf) begin
        run = 0;
        for (int i = n - 2; i >= 1 && ht[i] && run < MIN; i--) run++;
        if (run < MIN) set[1] = 1'b1;
      end
      if (dr) begin
        if (n > w_off) begin
          w_on = n + WD;
          w_off = n + WD + WP;
          if (m_dc != 16'hFFFF) m_dc++;
        end else set[2] = 1'b1;
      end
      m_ready = n >= ready_at;
      m_wire = n >= w_on && n < w_off;
    end else begin
      m_ready = 1'b0;
      m_wire = 1'b0;
      w_on = 0;
      w_off = 0;
    end
    prev_en = enable;
    m_err = (clear_errors ? 3'b000 : m_err) | set;
  endtask
  task automatic tick();
    @(posedge clock);
    model_step();
    #1;
    check("model", dut_out(), {m_ready, m_wire, m_tc, m_dc, m_err});
  endtask
  initial begin
    tbl = '{
      '{9,  1, 0, 0, 0, 0, 0, 0, 0, 3'b000},
      '{1,  1, 0, 0, 0, 1, 0, 0, 0, 3'b000},
      '{1,  1, 1, 0, 0, 1, 0, 0, 0, 3'b000},
      '{1,  1, 1, 0, 0, 0, 0, 1, 0, 3'b000},
      '{4,  1, 1, 0, 0, 0, 0, 1, 0, 3'b000},
      '{15, 1, 0, 0, 0, 0, 0, 1, 0, 3'b000},
      '{6,  1, 1, 0, 0, 0, 0, 1, 0, 3'b001},
      '{24, 1, 0, 0, 0, 0, 0, 1, 0, 3'b001},
      '{1,  1, 0, 0, 0, 1, 0, 1, 0, 3'b001},
      '{1,  1, 0, 0, 1, 1, 0, 1, 0, 3'b000},
      '{2,  1, 1, 0, 0, 0, 0, 2, 0, 3'b000},
      '{1,  1, 0, 0, 0, 0, 0, 2, 0, 3'b000},
      '{1,  1, 0, 0, 1, 0, 0, 2, 0, 3'b010},
      '{2,  1, 0, 1, 0, 0, 0, 2, 1, 3'b010},
      '{8,  1, 0, 0, 0, 0, 0, 2, 1, 3'b010},
      '{2,  1, 0, 1, 0, 0, 0, 2, 1, 3'b110},
      '{9,  1, 0, 0, 0, 0, 0, 2, 1, 3'b110},
      '{1,  1, 0, 0, 0, 0, 1, 2, 1, 3'b110},
      '{4,  1, 0, 0, 0, 0, 1, 2, 1, 3'b110},
      '{1,  1, 0, 0, 0, 0, 0, 2, 1, 3'b110},
      '{20, 1, 0, 0, 0, 0, 0, 2, 1, 3'b110},
      '{1,  1, 0, 0, 0, 1, 0, 2, 1, 3'b110},
      '{1,  1, 0, 0, 1, 1, 0, 2, 1, 3'b000},
      '{6,  1, 1, 0, 0, 0, 0, 3, 1, 3'b000},
      '{5,  1, 0, 0, 0, 0, 0, 3, 1, 3'b000},
      '{3,  0, 0, 1, 0, 0, 0, 3, 1, 3'b000},
      '{9,  1, 0, 0, 0, 0, 0, 3, 1, 3'b000},
      '{1,  1, 0, 0, 0, 1, 0, 3, 1, 3'b000}
    };
    model_reset();
    #1 reset_signal = 1'b1;
    repeat (2) @(posedge clock);
    #1 check("reset", dut_out(), 37'd0);
    @(negedge clock);
    reset_signal = 1'b0;
    model_reset();
    for (int i = 0; i < 28; i++) begin
      enable = tbl[i].en;
      output_trigger = tbl[i].tg;
      detonator_triggered = tbl[i].dt;
      clear_errors = tbl[i].cl;
      repeat (tbl[i].cyc) tick();
      check($sformatf("vec%0d", i), dut_out(), {tbl[i].rdy, tbl[i].wr, tbl[i].tc, tbl[i].dc, tbl[i].er});
    end
    enable = 1'b1;
    output_trigger = 1'b0;
    clear_errors = 1'b0;
    detonator_triggered = 1'b1;
    tick();
    detonator_triggered = 1'b0;
    repeat (22) tick();
    check("wire_mid_pulse", 37'(wire_sensor), 37'd1);
    #2 reset_signal = 1'b1;
    #1 check("async_reset", dut_out(), 37'd0);
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset_signal = 1'b0;
    model_reset();
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(5) == 0) output_trigger = ~output_trigger;
      if ($urandom_range(14) == 0) detonator_triggered = ~detonator_triggered;
      if (enable) begin
        if ($urandom_range(199) == 0) enable = 1'b0;
      end else if ($urandom_range(3) == 0) enable = 1'b1;
      clear_errors = $urandom_range(29) == 0;
      tick();
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
